btn_event_mmio: RTL and testbench

BTN_EVENT_MMIO -- requirements
Module: btn_event_mmio

---
 rtl/btn_event_mmio.sv | 181 ++++++++++++++++++
 tb/tb_btn_event_mmio.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/btn_event_mmio.sv
// Debounced push-button event capture with a timestamped event FIFO behind a two-word MMIO window.
// Presses latch into per-channel pending flags; an arbiter drains them into the FIFO lowest index first.
module btn_event_mmio #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TS_DIV          = 50000,
  parameter logic [11:0] ADDR_DATA       = 12'd7,
  parameter logic [11:0] ADDR_STATUS     = 12'd11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [11:0]        addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               hit,
  output logic               irq
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [NUM_BTN-1:0] r_sync1, r_sync2, r_stable, r_pend;
  logic [DB_W-1:0]    r_db_cnt [NUM_BTN];
  logic [DB_W-1:0]    w_db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] w_toggle, w_rise, w_grant, w_clr, w_pend_d;
  logic [7:0]         w_grant_idx;
  logic               w_found;

  logic [DIV_W-1:0]   r_div;
  logic [15:0]        r_ts;

  logic [23:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count, w_count_d;
  logic               r_ovf, r_irq;
  logic               w_full, w_empty, w_sel_data, w_sel_status;
  logic               w_flush, w_ovf_clr, w_ovf_set, w_push, w_pop;
  logic [23:0]        w_head;
  logic               w_unused_wdata;

  assign w_unused_wdata = ^wdata[31:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Counter runs only while the synchronized level disagrees with the accepted level.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_db_cnt_d[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_toggle[i] = 1'b1;
        end else begin
          w_db_cnt_d[i] = r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_rise = w_toggle & ~r_stable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_stable <= r_stable ^ w_toggle;
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= w_db_cnt_d[i];
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (r_pend[i] && !w_found) begin
        w_found     = 1'b1;
        w_grant[i]  = 1'b1;
        w_grant_idx = 8'(i);
      end
    end
  end

  assign w_sel_data   = (addr == ADDR_DATA);
  assign w_sel_status = (addr == ADDR_STATUS);
  assign hit          = w_sel_data | w_sel_status;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_flush   = wr_en & w_sel_status & wdata[0];
  assign w_ovf_clr = wr_en & w_sel_status & (wdata[0] | wdata[1]);
  assign w_push    = w_found & ~w_full & ~w_flush;
  assign w_pop     = rd_en & w_sel_data & ~w_empty & ~w_flush;
  assign w_clr     = w_push ? w_grant : '0;

  // A press on an already-pending channel is dropped; it only raises overflow.
  assign w_ovf_set = |(w_rise & r_pend);
  assign w_pend_d  = w_flush ? '0 : ((r_pend & ~w_clr) | (w_rise & ~r_pend));

  always_comb begin
    w_count_d = r_count;
    if (w_flush) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_pend  <= w_pend_d;
      r_ovf   <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      r_count <= w_count_d;
      r_irq   <= (w_count_d != '0);
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {w_grant_idx, r_ts};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_ts  <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_ts  <= r_ts + 16'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_head = r_mem[r_rptr];
  assign irq    = r_irq;

  always_comb begin
    rdata = '0;
    if (w_sel_data) begin
      if (!w_empty) rdata = {1'b1, 7'b0, w_head};
    end else if (w_sel_status) begin
      rdata = {r_ovf, 7'b0, 8'(r_count), 16'(r_stable)};
    end
  end

endmodule

// File: tb/tb_btn_event_mmio.sv
// Directed bench for btn_event_mmio: a vector table walked cycle by cycle from reset,
// followed by hand-written reset sequences.
module tb_btn_event_mmio;

  localparam logic [11:0] AD = 12'd7;
  localparam logic [11:0] AS = 12'd11;
  localparam logic [11:0] AX = 12'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic [11:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wdata, rdata;
  logic        hit, irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_event_mmio #(
    .NUM_BTN(4), .DEPTH(4), .DEBOUNCE_CYCLES(4), .TS_DIV(2),
    .ADDR_DATA(12'd7), .ADDR_STATUS(12'd11)
  ) dut (
    .clock(clk), .reset(rst_n), .btn_in(btn), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
  );

  typedef struct {
    logic [3:0]  btn;
    logic [11:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          ncyc;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] b, input logic [11:0] a, input logic r, input logic w,
                     input logic [31:0] wd, input int n, input logic c, input logic [31:0] er,
                     input logic ei, input logic eh);
    vec_t v;
    v.btn = b; v.addr = a; v.rd = r; v.wr = w; v.wdata = wd; v.ncyc = n;
    v.chk = c; v.exp_rdata = er; v.exp_irq = ei; v.exp_hit = eh;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Advance n rising edges; strobes last exactly one edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; addr = AS; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;

    // Edge numbers in the comments count rising edges after reset release.
    //   btn      addr rd wr wdata          n  chk exp_rdata     irq  hit
    add(4'b0000, AS, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 1);  // 0 reset status
    add(4'b0000, AD, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 1);  // 1 reset data
    add(4'b0000, AX, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 0);  // 2 unmapped
    add(4'b0000, 12'hFFF, 0, 0, 32'h0,     0, 1, 32'h00000000, 0, 0);  // 3 unmapped
    add(4'b0100, AS, 0, 0, 32'h0,          3, 1, 32'h00000000, 0, 1);  // 4 short glitch
    add(4'b0000, AS, 0, 0, 32'h0,         10, 0, 32'h0,        0, 0);  // 5 ->e13
    add(4'b0000, AS, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 1);  // 6 no event
    add(4'b0100, AD, 0, 0, 32'h0,          6, 1, 32'h00000000, 0, 1);  // 7 press 2 ->e19
    add(4'b0100, AS, 0, 0, 32'h0,          1, 1, 32'h00000004, 0, 1);  // 8 stable, not pushed
    add(4'b0100, AD, 1, 0, 32'h0,          1, 1, 32'h80020009, 1, 1);  // 9 pushed e20, pop e21
    add(4'b0100, AS, 0, 0, 32'h0,          0, 1, 32'h00000004, 0, 1);  // 10 empty again
    add(4'b0000, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 11 release ->e29
    add(4'b0000, AS, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 1);  // 12 release no event
    add(4'b1010, AS, 0, 0, 32'h0,          7, 0, 32'h0,        0, 0);  // 13 press 3+1 ->e36
    add(4'b1010, AS, 0, 0, 32'h0,          1, 1, 32'h0001000A, 1, 1);  // 14 one pushed
    add(4'b1010, AS, 0, 0, 32'h0,          0, 1, 32'h0002000A, 1, 1);  // 15 both pushed
    add(4'b1010, AD, 1, 0, 32'h0,          1, 1, 32'h80010011, 1, 1);  // 16 idx 1 first
    add(4'b1010, AD, 1, 0, 32'h0,          1, 1, 32'h80030012, 1, 1);  // 17 then idx 3
    add(4'b1010, AS, 0, 0, 32'h0,          0, 1, 32'h0000000A, 0, 1);  // 18 drained
    add(4'b0000, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 19 ->e47
    add(4'b0001, AS, 0, 0, 32'h0,          2, 0, 32'h0,        0, 0);  // 20 ch0 push e54
    add(4'b0011, AS, 0, 0, 32'h0,          2, 0, 32'h0,        0, 0);  // 21 ch1 push e56
    add(4'b0111, AS, 0, 0, 32'h0,          2, 0, 32'h0,        0, 0);  // 22 ch2 push e58
    add(4'b1111, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 23 ch3 push e60 ->e61
    add(4'b1110, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 24 release ch0 ->e69
    add(4'b1111, AS, 0, 0, 32'h0,          7, 0, 32'h0,        0, 0);  // 25 fifth press ->e76
    add(4'b1111, AS, 0, 0, 32'h0,          0, 1, 32'h0004000F, 1, 1);  // 26 full, fifth waits
    add(4'b1111, AD, 1, 0, 32'h0,          1, 1, 32'h8000001A, 1, 1);  // 27 pop e77
    add(4'b1111, AS, 0, 0, 32'h0,          1, 1, 32'h0003000F, 1, 1);  // 28 push e78
    add(4'b1111, AS, 0, 0, 32'h0,          0, 1, 32'h0004000F, 1, 1);  // 29 full again
    add(4'b1101, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 30 ->e86
    add(4'b1111, AS, 0, 0, 32'h0,          7, 0, 32'h0,        0, 0);  // 31 ch1 pending ->e93
    add(4'b1101, AS, 0, 0, 32'h0,          8, 0, 32'h0,        0, 0);  // 32 ->e101
    add(4'b1111, AS, 0, 0, 32'h0,          7, 0, 32'h0,        0, 0);  // 33 re-press ->e108
    add(4'b1111, AS, 0, 0, 32'h0,          0, 1, 32'h8004000F, 1, 1);  // 34 overflow set
    add(4'b1111, AS, 0, 1, 32'h2,          1, 1, 32'h8004000F, 1, 1);  // 35 clear ovf
    add(4'b1111, AS, 0, 0, 32'h0,          0, 1, 32'h0004000F, 1, 1);  // 36 ovf cleared
    add(4'b1111, AD, 0, 1, 32'hFFFFFFFF,   1, 1, 32'h8001001B, 1, 1);  // 37 data write
    add(4'b1111, AS, 0, 0, 32'h0,          0, 1, 32'h0004000F, 1, 1);  // 38 write ignored
    add(4'b1111, AS, 0, 1, 32'h1,          1, 0, 32'h0,        0, 0);  // 39 flush
    add(4'b1111, AS, 0, 0, 32'h0,          3, 1, 32'h0000000F, 0, 1);  // 40 flushed
    add(4'b1111, AD, 0, 0, 32'h0,          0, 1, 32'h00000000, 0, 1);  // 41 pending cleared too

    step(1);
    addr = AS; #1;
    check("rst_status", 0, rdata, 32'h0);
    check("rst_irq", 0, {31'b0, irq}, 32'h0);
    addr = AD; #1;
    check("rst_data", 0, rdata, 32'h0);
    step(1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn = vecs[i].btn; addr = vecs[i].addr; rd_en = vecs[i].rd;
      wr_en = vecs[i].wr; wdata = vecs[i].wdata;
      #1;
      if (vecs[i].chk) begin
        check("rdata", i, rdata, vecs[i].exp_rdata);
        check("irq", i, {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        check("hit", i, {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      end
      step(vecs[i].ncyc);
    end

    // Two queued events, then an asynchronous reset with buttons 0 and 2 still held.
    btn = 4'b0000; addr = AS;
    step(8);
    btn = 4'b0101;
    step(8);
    #1;
    check("q2_status", 0, rdata, 32'h00020005);
    check("q2_irq", 0, {31'b0, irq}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_status", 0, rdata, 32'h0);
    check("async_irq", 0, {31'b0, irq}, 32'h0);
    addr = AD; #1;
    check("async_data", 0, rdata, 32'h0);
    step(3);
    rst_n = 1'b1;
    addr = AS;
    step(6);
    #1;
    check("held_stable", 0, rdata, 32'h00000005);
    check("held_irq_early", 0, {31'b0, irq}, 32'h0);
    step(1);
    addr = AD; #1;
    check("held_head", 0, rdata, 32'h80000003);
    check("held_irq", 0, {31'b0, irq}, 32'h1);
    step(1);
    addr = AS; #1;
    check("held_count", 0, rdata, 32'h00020005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
